// File: rtl/mul_div_pkg.sv
// Purpose: shared types and helpers for the iterative multiply/divide units.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: XLEN, the IDLE/BUSY/DONE state enum shared by both FSMs, and abs_w().
package mul_div_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Magnitude of v when signed_en is set. The most negative value maps to
    // 2^(XLEN-1). Read as unsigned, that result is still the correct magnitude.
    function automatic logic [XLEN-1:0] abs_w(input logic [XLEN-1:0] v,
                                              input logic            signed_en);
        return (signed_en && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_acc_adder.sv
// Purpose: N-bit adder with carry in/out for the partial-product accumulate.
// Latency: combinational.
// Backpressure: none.
// Ports: src1/src2 operands, cin carry in, result N-bit sum, cout carry out.
module mul_acc_adder #(
    parameter int N = 33
) (
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic         cin,
    output logic [N-1:0] result,
    output logic         cout
);

    assign {cout, result} = {1'b0, src1} + {1'b0, src2} + {{N{1'b0}}, cin};

endmodule

// File: rtl/shift_add_mul.sv
// Purpose: iterative radix-2 shift-and-add multiplier, signed or unsigned, W x W -> 2W.
// Latency: W+1 cycles from accept to out_valid; one product per W+2 cycles back to back.
// Backpressure: out_ready low holds DONE and p indefinitely; in_ready is high only in IDLE.
// Ports: clk, reset (sync, active high); x, y, mul_signed, in_valid/in_ready request side;
//        p, out_valid/out_ready result side.
module shift_add_mul
    import mul_div_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           mul_signed,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      mcand_q, mcand_d;
    logic [2*W:0]      acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [2*W-1:0]    p_q, p_d;

    logic [W:0]        add_res;
    logic              add_cout;
    logic [2*W:0]      acc_step;

    mul_acc_adder #(.N(W+1)) u_adder (
        .src1   (acc_q[2*W:W]),
        .src2   ({1'b0, mcand_q}),
        .cin    (1'b0),
        .result (add_res),
        .cout   (add_cout)
    );

    // Add-then-shift folded into one select. The shift drops acc[0], so the
    // carry lands in the top bit. The carry is always zero because the upper
    // half never exceeds 2^W - 1 before the add.
    assign acc_step = acc_q[0] ? {add_cout, add_res, acc_q[W-1:1]}
                               : {1'b0, acc_q[2*W:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = abs_w(x, mul_signed);
                    acc_d   = {{(W+1){1'b0}}, abs_w(y, mul_signed)};
                    neg_d   = mul_signed & (x[W-1] ^ y[W-1]);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    state_d = DONE;
                    p_d     = neg_q ? (~acc_step[2*W-1:0] + {{(2*W-1){1'b0}}, 1'b1})
                                    : acc_step[2*W-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Purpose: self-checking bench for shift_add_mul against an arithmetic reference.
// Latency: n/a.
// Backpressure: exercises out_ready held low and tied high.
module tb_shift_add_mul;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] x, y;
    logic        mul_signed;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_add_mul dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .mul_signed (mul_signed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p)
    );

    // Reference: extend both operands to 64 bits according to signedness and
    // keep the low 64 bits of the product.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, lets the accept edge pass, then scrambles the
    // operand inputs so later sampling would be caught.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        x          = a;
        y          = b;
        mul_signed = s;
        in_valid   = 1'b1;
        check("req_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid   = 1'b0;
        x          = $urandom;
        y          = $urandom;
        mul_signed = ~s;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid appears.
    // With pulse set, a stray request is offered in the middle of BUSY.
    task automatic wait_done(input bit pulse, output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (pulse && lat == 5) in_valid = 1'b1;
            if (pulse && lat == 6) in_valid = 1'b0;
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_out_valid", 64'(out_valid), 64'd0);
        check("consume_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [63:0] exp);
        int lat;
        start_op(a, b, s);
        wait_done(1'b0, lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_p"}, p, exp);
        consume();
        check({tag, "_p_held"}, p, exp);
    endtask

    initial begin
        int          lat;
        logic [31:0] a, b;
        logic        s;
        logic [63:0] exp;

        reset      = 1'b1;
        x          = '0;
        y          = '0;
        mul_signed = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", p, 64'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        directed("uns_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        directed("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        directed("u_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);
        directed("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        directed("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        directed("s_zero_neg", 32'd0, 32'hFFFF_FFF0, 1'b1, 64'd0);

        // Backpressure with stray requests during BUSY and DONE.
        a = $urandom;
        b = $urandom;
        exp = ref_mul(a, b, 1'b1);
        start_op(a, b, 1'b1);
        wait_done(1'b1, lat);
        check("bp_lat", 64'(lat), 64'd33);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            x        = 32'd99;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_p", p, exp);
            tick();
        end
        in_valid = 1'b0;
        consume();
        tick();
        check("bp_no_stray_in_ready", 64'(in_ready), 64'd1);
        check("bp_no_stray_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of BUSY discards the operation.
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (14) tick();
        check("mid_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_p", p, 64'd0);
        directed("after_rst", 32'd6, 32'd7, 1'b0, 64'd42);

        // Back-to-back random traffic with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 50 == 0) a = 32'h8000_0000;
            if (i % 77 == 0) b = 32'h0;
            x          = a;
            y          = b;
            mul_signed = s;
            exp        = ref_mul(a, b, s);
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            tick();
            x = $urandom;
            y = $urandom;
            mul_signed = ~s;
            lat = 1;
            while (!out_valid && lat < 200) begin
                tick();
                lat++;
            end
            check("b2b_lat", 64'(lat), 64'd33);
            check("b2b_p", p, exp);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mul.md
Name: shift_add_mul

Overview:
Iterative radix-2 shift-and-add multiplier for 32-bit signed or unsigned operands, producing a 64-bit product. It is the multiply counterpart of the team's iterative restoring divider and uses the same in_valid/in_ready request handshake. It adds an out_ready backpressure handshake on the result side. It sits in the ALU's multi-cycle execution path alongside the divider.

Parameters:
W, 32, operand width; product is 2*W; the iteration counter is clog2(W) bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
x  input  W  multiplicand, sampled only on accept.
y  input  W  multiplier, sampled only on accept.
mul_signed  input  1  1 = both operands are two's complement; 0 = both unsigned. Sampled on accept.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request; high only in IDLE.
out_valid  output  1  product valid; held until it is consumed.
out_ready  input  1  consumer accepts the product.
p  output  2W  product; stable while out_valid is high.

Behaviour:
- Reset values: in_ready=1, out_valid=0, p=0, state=IDLE, counter=0. Reset is synchronous, active-high, and overrides everything, including mid-computation (the result is discarded) and an unconsumed result.
- FSM states are IDLE, BUSY and DONE.
- IDLE, accept condition (in_valid & in_ready):
  - latch |x| into a W-bit multiplicand register;
  - latch |y| into the low half of a 2W+1-bit accumulator, with the upper W+1 bits cleared;
  - latch neg = mul_signed & (x[W-1] ^ y[W-1]);
  - clear the counter and go to BUSY.
  - With no accept, the state holds.
- Absolute value: if mul_signed and the sign bit is set, take ~v+1; otherwise v unchanged. |-2^31| = 0x8000_0000 is treated as unsigned and is correct.
- BUSY, each cycle:
  - if acc[0]=1, acc[2W:W] = acc[2W:W] + multiplicand (W+1-bit add, no overflow possible); otherwise unchanged;
  - then shift acc right by 1, zero fill;
  - increment the counter.
  - On the step where counter == W-1, go to DONE and register p = neg ? (~acc_next[2W-1:0] + 1) : acc_next[2W-1:0].
- Timing: request accepted at edge 0; BUSY covers edges 1..W; out_valid goes high after edge W. Latency is W+1 cycles from accept to out_valid, i.e. 33 for W=32.
- DONE: out_valid=1 and in_ready=0. On out_valid & out_ready, go to IDLE: out_valid=0 and in_ready=1 after that edge. p holds its value until the next DONE entry; it is not cleared on consume.
- No same-cycle consume plus accept. in_valid is ignored outside IDLE. There is a minimum 1-cycle IDLE gap between operations, so the back-to-back throughput is one product per W+2 cycles.
- Backpressure: out_ready low keeps DONE indefinitely. out_ready is ignored outside DONE.
- Operands x, y and mul_signed may change freely after accept; they have no effect until the next accept.
- Zero operand needs no early termination; it takes the full W iterations and yields p=0. A negated zero stays 0.

Decomposition:
- Shared package mul_div_pkg:
  - constant XLEN=32;
  - state enumeration IDLE/BUSY/DONE, to be shared with the divider's FSM;
  - function abs_w(v, signed_en).
- One sub-module, mul_acc_adder: a (W+1)-bit adder with src1, src2, cin, cout and result, used for the partial-product accumulate. The final 2W-bit negation is done inline.

Test Plan:
1. Unsigned: x=0xFFFF_FFFF, y=0xFFFF_FFFF, mul_signed=0 -> out_valid exactly 33 cycles after accept; p=0xFFFF_FFFE_0000_0001.
2. Signed mixed: x=-3 (0xFFFF_FFFD), y=7, mul_signed=1 -> p=0xFFFF_FFFF_FFFF_FFEB (-21); the same operands with mul_signed=0 -> p=0x0000_0006_FFFF_FFEB.
3. Signed corner: x=y=0x8000_0000, mul_signed=1 -> p=0x4000_0000_0000_0000; x=0x8000_0000, y=1 -> p=0xFFFF_FFFF_8000_0000.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and p stay stable and in_ready stays 0. A pulsed in_valid during BUSY/DONE is ignored. Raising out_ready -> out_valid=0 and in_ready=1 on the next cycle.
5. Reset mid-op: assert reset at BUSY cycle 15 -> the next cycle shows in_ready=1, out_valid=0, p=0. A new request x=6, y=7 then yields p=42 with full 33-cycle latency.
6. Back-to-back with out_ready tied high: 1000 random signed/unsigned pairs compared against a reference model -> every p matches, and the out_valid-to-next-accept spacing is 1 cycle.
